// File: rtl/div16_seq_if.sv
// rtl/div16_seq_if.sv - start/done handshake and operand/result bus of the sequential divider
interface div16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Issuing controller side
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_seq.sv
// rtl/div16_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    div16_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] divisor_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH:0]   r_shift;
    logic             r_ge;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        r_ge    = (r_shift >= {1'b0, divisor_q});
        r_d     = r_ge ? (r_shift - {1'b0, divisor_q}) : r_shift;
        q_d     = {q_q[WIDTH-2:0], r_ge};
    end

    // Control FSM and datapath; the cycle after the last step commits results and raises done.
    // A zero divisor enters CALC with count 0, so it commits on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            r_q       <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        q_q       <= bus.dividend;
                        divisor_q <= bus.divisor;
                        r_q       <= '0;
                        dz_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        count_q   <= (bus.divisor == '0) ? '0 : CW'(WIDTH);
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (count_q != '0) begin
                        r_q     <= r_d;
                        q_q     <= q_d;
                        count_q <= count_q - 1'b1;
                    end else begin
                        if (divisor_q == '0) begin
                            quot_q <= '1;
                            rem_q  <= q_q;
                            dz_q   <= 1'b1;
                        end else begin
                            quot_q <= q_q;
                            rem_q  <= r_q[WIDTH-1:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_div16_seq.sv
// tb/tb_div16_seq.sv - randomized self-checking bench for div16_seq against an arithmetic reference
module tb_div16_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div16_seq_if #(.WIDTH(16)) bus ();

    div16_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dz);
        if (b == 16'd0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; lat = cycles elapsed from the call
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            lat++;
            if (lat > 60) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [15:0] eq, er;
        logic        edz;
        int          lat, bc;
        ref_div(a, b, eq, er, edz);
        launch(a, b);
        wait_done(lat, bc);
        chk({tag, "_lat"},  lat, edz ? 32'd1 : 32'd17);
        chk({tag, "_busy_cycles"}, bc, edz ? 32'd1 : 32'd17);
        chk({tag, "_q"},    bus.quotient, eq);
        chk({tag, "_r"},    bus.remainder, er);
        chk({tag, "_dz"},   bus.div_by_zero, edz);
        chk({tag, "_busy_in_done"}, bus.busy, 1'b1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 2'b00);
        chk({tag, "_q_held"}, bus.quotient, eq);
    endtask

    initial begin
        int lat, bc, seen;
        logic [15:0] a, b;
        int sel;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_q",    bus.quotient, 16'd0);
        chk("rst_r",    bus.remainder, 16'd0);
        chk("rst_dz",   bus.div_by_zero, 1'b0);
        rst_n = 1'b1;

        // Directed cases
        do_div(16'd100,   16'd7,    "d_100_7");
        do_div(16'hFFFF,  16'd1,    "d_ffff_1");
        do_div(16'hFFFF,  16'hFFFF, "d_ffff_ffff");
        do_div(16'd3,     16'd10,   "d_3_10");
        do_div(16'd0,     16'd5,    "d_0_5");
        do_div(16'd1234,  16'd0,    "d_1234_0");
        do_div(16'd9,     16'd3,    "d_9_3");

        // Start pulse and operand change during CALC are ignored
        launch(16'd100, 16'd7);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 16'd999;
        wait_done(lat, bc);
        chk("ign_q", bus.quotient, 16'd14);
        chk("ign_r", bus.remainder, 16'd2);
        @(negedge clk);

        // Start held high: re-accepted one idle cycle after DONE, ignored in DONE
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd3;
        wait_done(lat, bc);
        chk("b2b_q1", bus.quotient, 16'd3);
        wait_done(lat, bc);
        chk("b2b_gap", lat, 32'd18);
        chk("b2b_q2", bus.quotient, 16'd3);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-CALC aborts without a done
        launch(16'd100, 16'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_q",    bus.quotient, 16'd0);
        chk("abort_r",    bus.remainder, 16'd0);
        chk("abort_done", bus.done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort_no_done", seen, 32'd0);
        do_div(16'd200, 16'd9, "d_200_9");

        // Random pairs, biased toward zero and small divisors
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            a   = 16'($urandom);
            if (sel == 0)      b = 16'd0;
            else if (sel < 4)  b = 16'($urandom_range(1, 15));
            else               b = 16'($urandom);
            do_div(a, b, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
